// File: rtl/prescaler_pkg.sv
`default_nettype none
// prescaler_pkg -- shared width, default divisors and the zero-to-one divisor clamp.
// Rev 1.0
package prescaler_pkg;

  localparam int CNT_W        = 27;
  localparam int DIV_DEFAULT  = 833_333;   // 120 Hz tick at 100 MHz
  localparam int DIV_120HZ_SQ = 416_667;   // 120 Hz square wave on o_clk at 100 MHz

  // A divisor of zero behaves like a divisor of one.
  function automatic logic [31:0] eff_div(input logic [31:0] val);
    return (val == 32'd0) ? 32'd1 : val;
  endfunction

endpackage
`default_nettype wire

// File: rtl/prescaler_channel.sv
`default_nettype none
// prescaler_channel -- one divider: divisor register, counter, tick flop and optional toggle flop.
// Rev 1.0; the toggle output is built only when PRESCALER_CLK_OUT_EN is defined.
module prescaler_channel #(
  parameter int CNT_W       = prescaler_pkg::CNT_W,
  parameter int DIV_DEFAULT = prescaler_pkg::DIV_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             tick,
  output logic             clk_out
);
  import prescaler_pkg::*;

  logic [CNT_W-1:0] div;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] last;
  logic             wrap;

  assign last = CNT_W'(eff_div(32'(div)) - 32'd1);
  // A load on the wrap cycle wins: no wrap, no tick, no toggle.
  assign wrap = enable && !load && (cnt == last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div  <= CNT_W'(DIV_DEFAULT);
      cnt  <= '0;
      tick <= 1'b0;
    end else if (load) begin
      div  <= load_val;
      cnt  <= '0;
      tick <= 1'b0;
    end else if (enable) begin
      if (wrap) begin
        cnt  <= '0;
        tick <= 1'b1;
      end else begin
        cnt  <= cnt + CNT_W'(1);
        tick <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

`ifdef PRESCALER_CLK_OUT_EN
  logic clk_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_q <= 1'b0;
    end else if (wrap) begin
      clk_q <= ~clk_q;
    end
  end

  assign clk_out = clk_q;
`else
  assign clk_out = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/prescaler_multi.sv
`default_nettype none
// prescaler_multi -- N_CH run-time programmable prescalers with a strobe/ack divisor write port.
// Rev 1.0; define PRESCALER_CLK_OUT_EN to build the o_clk square-wave outputs.
module prescaler_multi #(
  parameter int N_CH        = 4,
  parameter int CNT_W       = prescaler_pkg::CNT_W,
  parameter int DIV_DEFAULT = prescaler_pkg::DIV_DEFAULT,
  localparam int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_enable,
  input  logic             i_div_wr,
  input  logic [CH_W-1:0]  i_div_ch,
  input  logic [CNT_W-1:0] i_div_val,
  output logic             o_div_ack,
  output logic [N_CH-1:0]  o_tick,
  output logic [N_CH-1:0]  o_clk
);

  logic [N_CH-1:0] load;
  logic            wr_valid;

  // Indices beyond the last channel are dropped and never acknowledged.
  assign wr_valid = i_div_wr && (int'(i_div_ch) < N_CH);

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    assign load[c] = wr_valid && (i_div_ch == CH_W'(c));

    prescaler_channel #(
      .CNT_W      (CNT_W),
      .DIV_DEFAULT(DIV_DEFAULT)
    ) u_channel (
      .clk     (i_clk),
      .rst_n   (i_reset),
      .enable  (i_enable),
      .load    (load[c]),
      .load_val(i_div_val),
      .tick    (o_tick[c]),
      .clk_out (o_clk[c])
    );
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_div_ack <= 1'b0;
    end else begin
      o_div_ack <= wr_valid;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_prescaler_multi.sv
`default_nettype none
// tb_prescaler_multi -- directed bench for prescaler_multi (5 channels, default divisor 6).
// Rev 1.0
module tb_prescaler_multi;

  localparam int N  = 5;
  localparam int CW = 27;
`ifdef PRESCALER_CLK_OUT_EN
  localparam bit CLK_EN = 1'b1;
`else
  localparam bit CLK_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic          div_wr;
  logic [2:0]    div_ch;
  logic [CW-1:0] div_val;
  logic          div_ack;
  logic [N-1:0]  tick;
  logic [N-1:0]  clk_o;

  int checks = 0;
  int errors = 0;

  prescaler_multi #(
    .N_CH       (N),
    .CNT_W      (CW),
    .DIV_DEFAULT(6)
  ) dut (
    .i_clk    (clk),
    .i_reset  (rst_n),
    .i_enable (enable),
    .i_div_wr (div_wr),
    .i_div_ch (div_ch),
    .i_div_val(div_val),
    .o_div_ack(div_ack),
    .o_tick   (tick),
    .o_clk    (clk_o)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] ck(input logic [N-1:0] v);
    return CLK_EN ? v : '0;
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; enable = 1'b0; div_wr = 1'b0; div_ch = '0; div_val = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; div_wr = 1'b0; div_ch = '0; div_val = '0;
    #1;
    checks++; if (tick !== '0 || clk_o !== '0 || div_ack !== 1'b0) begin
      errors++; $display("FAIL reset_init tick=%b clk=%b ack=%b exp 0", tick, clk_o, div_ack); end
    @(negedge clk);
    rst_n = 1'b1; enable = 1'b1; div_wr = 1'b1; div_ch = 3'd1; div_val = CW'(3);
    step();
    div_wr = 1'b0;
    for (int s = 1; s <= 5; s++) step();
    checks++; if (tick !== 5'b11101 || clk_o !== ck(5'b11111)) begin
      errors++; $display("FAIL reset_precount tick=%b clk=%b exp %b %b", tick, clk_o, 5'b11101, ck(5'b11111)); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (tick !== '0 || clk_o !== '0 || div_ack !== 1'b0) begin
      errors++; $display("FAIL reset_async tick=%b clk=%b ack=%b exp 0", tick, clk_o, div_ack); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int s = 1; s <= 6; s++) begin
      step();
      checks++; if (tick !== ((s == 6) ? 5'b11111 : 5'b00000)) begin
        errors++; $display("FAIL reset_default_div s=%0d tick=%b exp %b", s, tick, (s == 6) ? 5'b11111 : 5'b00000); end
    end
  endtask

  task automatic test_defaults();
    logic [N-1:0] et, ec;
    do_reset();
    enable = 1'b1;
    for (int s = 1; s <= 12; s++) begin
      step();
      et = (s % 6 == 0) ? '1 : '0;
      ec = ck((((s / 6) % 2) == 1) ? '1 : '0);
      checks++; if (tick !== et || clk_o !== ec) begin
        errors++; $display("FAIL defaults s=%0d tick=%b clk=%b exp %b %b", s, tick, clk_o, et, ec); end
    end
  endtask

  task automatic test_write_ch1();
    logic [N-1:0] et, ec;
    do_reset();
    enable = 1'b1; div_wr = 1'b1; div_ch = 3'd1; div_val = CW'(5);
    step();
    div_wr = 1'b0;
    checks++; if (div_ack !== 1'b1 || tick !== '0) begin
      errors++; $display("FAIL write_ch1_ack ack=%b tick=%b exp 1 00000", div_ack, tick); end
    for (int s = 1; s <= 15; s++) begin
      step();
      for (int c = 0; c < N; c++) begin
        et[c] = (c == 1) ? (s % 5 == 0) : ((s + 1) % 6 == 0);
        ec[c] = (c == 1) ? ((s / 5) % 2 == 1) : (((s + 1) / 6) % 2 == 1);
      end
      ec = ck(ec);
      checks++; if (tick !== et || clk_o !== ec || (s == 1 && div_ack !== 1'b0)) begin
        errors++; $display("FAIL write_ch1 s=%0d tick=%b clk=%b ack=%b exp %b %b", s, tick, clk_o, div_ack, et, ec); end
    end
  endtask

  task automatic test_div_zero_one();
    do_reset();
    enable = 1'b1; div_wr = 1'b1; div_ch = 3'd2; div_val = CW'(0);
    step();
    div_wr = 1'b0;
    checks++; if (div_ack !== 1'b1 || tick !== '0) begin
      errors++; $display("FAIL div0_ack ack=%b tick=%b exp 1 00000", div_ack, tick); end
    for (int s = 1; s <= 4; s++) begin
      step();
      checks++; if (tick !== 5'b00100 || clk_o[2] !== (CLK_EN && (s % 2 == 1))) begin
        errors++; $display("FAIL div0 s=%0d tick=%b clk2=%b exp 00100 %b", s, tick, clk_o[2], CLK_EN && (s % 2 == 1)); end
    end
    div_wr = 1'b1; div_val = CW'(1);
    step();
    div_wr = 1'b0;
    checks++; if (div_ack !== 1'b1 || tick !== 5'b11011 || clk_o[2] !== 1'b0) begin
      errors++; $display("FAIL div1_wrwin ack=%b tick=%b clk2=%b exp 1 11011 0", div_ack, tick, clk_o[2]); end
    for (int t = 1; t <= 4; t++) begin
      step();
      checks++; if (tick !== 5'b00100 || clk_o[2] !== (CLK_EN && (t % 2 == 1))) begin
        errors++; $display("FAIL div1 t=%0d tick=%b clk2=%b exp 00100 %b", t, tick, clk_o[2], CLK_EN && (t % 2 == 1)); end
    end
  endtask

  task automatic test_wrap_write();
    logic [N-1:0] et;
    do_reset();
    enable = 1'b1; div_wr = 1'b1; div_ch = 3'd0; div_val = CW'(4);
    step();
    div_wr = 1'b0;
    for (int s = 1; s <= 7; s++) begin
      step();
      et = (s == 4) ? 5'b00001 : (s == 5) ? 5'b11110 : 5'b00000;
      checks++; if (tick !== et) begin
        errors++; $display("FAIL wrap_pre s=%0d tick=%b exp %b", s, tick, et); end
    end
    div_wr = 1'b1;
    step();
    div_wr = 1'b0;
    checks++; if (div_ack !== 1'b1 || tick !== 5'b00000) begin
      errors++; $display("FAIL wrap_write ack=%b tick=%b exp 1 00000", div_ack, tick); end
    for (int t = 1; t <= 4; t++) begin
      step();
      et = (t == 3) ? 5'b11110 : (t == 4) ? 5'b00001 : 5'b00000;
      checks++; if (tick !== et) begin
        errors++; $display("FAIL wrap_post t=%0d tick=%b exp %b", t, tick, et); end
    end
  endtask

  task automatic test_enable();
    logic [N-1:0] et_tab [4];
    logic [N-1:0] ec_tab [4];
    et_tab = '{5'b00000, 5'b00100, 5'b00010, 5'b11101};
    ec_tab = '{5'b11111, 5'b11011, 5'b11001, 5'b00100};
    do_reset();
    enable = 1'b1; div_wr = 1'b1; div_ch = 3'd1; div_val = CW'(5);
    step();
    div_wr = 1'b0;
    for (int s = 1; s <= 7; s++) begin
      step();
      if (s == 5) begin
        checks++; if (tick !== 5'b11111) begin
          errors++; $display("FAIL enable_pre tick=%b exp 11111", tick); end
      end
    end
    enable = 1'b0;
    for (int d = 1; d <= 10; d++) begin
      step();
      checks++; if (tick !== '0 || clk_o !== ck(5'b11111) || (d == 5 && div_ack !== 1'b1)) begin
        errors++; $display("FAIL enable_hold d=%0d tick=%b clk=%b ack=%b exp 00000 %b", d, tick, clk_o, div_ack, ck(5'b11111)); end
      div_wr = (d == 4);
      div_ch = 3'd2; div_val = CW'(2);
    end
    enable = 1'b1;
    for (int r = 1; r <= 4; r++) begin
      step();
      checks++; if (tick !== et_tab[r-1] || clk_o !== ck(ec_tab[r-1])) begin
        errors++; $display("FAIL enable_resume r=%0d tick=%b clk=%b exp %b %b", r, tick, clk_o, et_tab[r-1], ck(ec_tab[r-1])); end
    end
  endtask

  task automatic test_bad_ch();
    do_reset();
    enable = 1'b1; div_wr = 1'b1; div_ch = 3'd5; div_val = CW'(2);
    for (int s = 0; s <= 5; s++) begin
      step();
      div_ch = 3'd7;
      if (s == 1) div_wr = 1'b0;
      checks++; if (div_ack !== 1'b0 || tick !== ((s == 5) ? 5'b11111 : 5'b00000)) begin
        errors++; $display("FAIL bad_ch s=%0d ack=%b tick=%b exp 0 %b", s, div_ack, tick, (s == 5) ? 5'b11111 : 5'b00000); end
    end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] et;
    do_reset();
    enable = 1'b1; div_wr = 1'b1; div_ch = 3'd3; div_val = CW'(9);
    for (int s = 0; s <= 8; s++) begin
      step();
      if (s == 0) begin div_ch = 3'd3; div_val = CW'(3); end
      if (s == 1) begin div_ch = 3'd4; div_val = CW'(2); end
      if (s == 2) div_wr = 1'b0;
      for (int c = 0; c < N; c++)
        et[c] = (c == 3) ? (s == 4 || s == 7) : (c == 4) ? (s == 4 || s == 6 || s == 8) : (s == 5);
      checks++; if (tick !== et || div_ack !== (s <= 2)) begin
        errors++; $display("FAIL back_to_back s=%0d tick=%b ack=%b exp %b %b", s, tick, div_ack, et, s <= 2); end
    end
  endtask

  initial begin
    test_reset();
    test_defaults();
    test_write_ch1();
    test_div_zero_one();
    test_wrap_write();
    test_enable();
    test_bad_ch();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
